controle_horner: RTL and testbench
==================================

# controle_horner

Parametrised control sequencer for the polynomial/multiply datapath: drives register loads, the reg1 source mux, the add/sub operation and the coefficient ROM address, evaluating acc = acc·x ± coef[i] over a run-time term count (Horner form). Successor to the fixed ten-state controller:
- variable term count;
- handshake with a multi-cycle multiplier;
- start/busy/done protocol;
- abort;
- proper reset.

## Interface
- N_TERMS, default 4: maximum number of coefficients per evaluation.
- ADDR_W, default 4: coefficient ROM address width; must satisfy 2^ADDR_W ≥ N_TERMS.
- SEL_W, default 3: width of the reg1 source-mux select.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request evaluation; sampled only in IDLE.
- abort  in  1  cancel evaluation; returns to IDLE next cycle.
- mode  in  1  0: add coefficient, 1: subtract; latched at start.
- cfg_terms  in  ADDR_W  number of terms; latched at start.
- mul_done  in  1  multiplier result valid (product on datapath).
- busy  out  1  high from INIT through DONE inclusive.
- done  out  1  one-cycle pulse in DONE.
- load_reg1  out  1  load accumulator.
- load_reg2  out  1  load x operand.
- load_reg3  out  1  load product register.
- op  out  1  datapath add/sub select (latched mode).
- mux_load_reg1  out  SEL_W  reg1 source: SEL_ZERO=0, SEL_ROM=1, SEL_SUM=2.
- rom_addr  out  ADDR_W  coefficient address.
- mul_start  out  1  one-cycle multiply request.

## Operation
- States: IDLE, INIT, MUL, WAIT, ADD, DONE. Registered state, Moore decode, except load_reg3, which is Mealy in WAIT.
- Term count T = cfg_terms at start. Values of 0 are treated as 1; values > N_TERMS saturate to N_TERMS. A term index i counts 0..T-1.
- IDLE: all outputs 0. start=1 and abort=0 → latch T, mode; i←0; → INIT.
- INIT: rom_addr=0, mux_load_reg1=SEL_ROM, load_reg1=1, load_reg2=1. → DONE if T==1, else MUL.
- MUL: mul_start=1 for exactly one cycle. → WAIT.
- WAIT: load_reg3=mul_done. On mul_done: i←i+1, → ADD. Otherwise stay; no timeout.
- ADD: rom_addr=i, mux_load_reg1=SEL_SUM, op=mode, load_reg1=1. → DONE if i==T-1, else MUL.
- DONE: done=1. → IDLE.
- abort=1 in any non-IDLE state → IDLE next edge. No done is issued. Load strobes in the abort cycle still follow the current state's decode. abort wins over start when both are high in IDLE.
- start while busy is ignored, with no queueing. mul_done outside WAIT is ignored.
- op is held at the latched mode throughout busy; it is 0 in IDLE.

## Timing
- rst_n low: state=IDLE; T, i, mode = 0. All outputs 0 immediately (asynchronous). Deassertion is synchronised by the surrounding reset tree. Reset mid-evaluation discards the run; no done.
- Cycle 0 = first edge with start high in IDLE. INIT occupies cycle 1; MUL occupies cycle 2.
- Multiplier latency L ≥ 1: mul_done is high L cycles after the MUL cycle.
- Each term after the first costs L+2 cycles (MUL, L WAIT cycles, ADD).
- DONE occurs in cycle 2+(T-1)(L+2). busy is high for cycles 1 through that cycle.
- A new start is accepted in the cycle after DONE (back-to-back run gap = 1 IDLE cycle).

## Structure
- Package controle_horner_pkg: state enum, SEL_ZERO/SEL_ROM/SEL_SUM constants, a saturate-terms function.
- One sub-module, term_counter: latches T, holds the index i, and flags last = (i==T-1). It has clear, load and inc inputs.
- FSM and output decode stay in controle_horner.

## Test plan
- Reset mid-run: assert rst_n=0 during WAIT → all outputs 0 within the same cycle; after release, start → full run completes normally.
- T=1, start pulse → INIT at cycle 1 (load_reg1, load_reg2, SEL_ROM, rom_addr=0), done at cycle 2, mul_start never asserted.
- T=4, L=1, mode=0 → rom_addr sequence 0,1,2,3 on SEL_ROM/SEL_SUM loads; three mul_start pulses; done at cycle 11; op=0 throughout.
- T=3, mode=1, mul_done delayed L=5 → WAIT held 5 cycles each; op=1 during busy; done at cycle 16; spurious mul_done pulses in MUL/ADD have no effect.
- cfg_terms=0 → behaves as T=1. cfg_terms=15 with N_TERMS=4 → behaves as T=4, with last rom_addr=3.
- abort in the second WAIT → IDLE next cycle, no done, busy low. start together with abort in IDLE → stays IDLE. start during busy → ignored.

Source files
------------

// File: rtl/controle_horner_pkg.sv
// Shared types and helpers for the Horner-evaluation control sequencer.
package controle_horner_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MUL,
        S_WAIT,
        S_ADD,
        S_DONE
    } state_t;

    // reg1 source-mux encodings
    localparam int unsigned SEL_ZERO = 0;
    localparam int unsigned SEL_ROM  = 1;
    localparam int unsigned SEL_SUM  = 2;

    // A term count of 0 means one term; counts above the maximum clamp to it.
    function automatic int unsigned saturate_terms(input int unsigned cfg,
                                                   input int unsigned max_terms);
        int unsigned t;
        t = cfg;
        if (t == 0) begin
            t = 1;
        end else if (t > max_terms) begin
            t = max_terms;
        end
        return t;
    endfunction

endpackage

// File: rtl/controle_horner_term_counter.sv
// Term bookkeeping: latched term count T, running index i and last-term flag.
module term_counter
    import controle_horner_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] cfg_terms,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);

    // One extra bit so that T == 2^ADDR_W is representable.
    localparam int unsigned TW = ADDR_W + 1;

    logic [TW-1:0] terms;

    // Latch the saturated count at start, clear on exit, step the index per term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terms <= '0;
            idx   <= '0;
        end else if (clear) begin
            terms <= '0;
            idx   <= '0;
        end else if (load) begin
            terms <= TW'(saturate_terms(32'(cfg_terms), N_TERMS));
            idx   <= '0;
        end else if (inc) begin
            idx   <= idx + ADDR_W'(1);
        end
    end

    // Last term reached when i == T-1 (never true while cleared, T == 0).
    always_comb begin
        last = ({1'b0, idx} == (terms - TW'(1)));
    end

endmodule

// File: rtl/controle_horner.sv
// Control sequencer for Horner evaluation acc = acc*x +/- coef[i].
module controle_horner
    import controle_horner_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned SEL_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] cfg_terms,
    input  logic              mul_done,
    output logic              busy,
    output logic              done,
    output logic              load_reg1,
    output logic              load_reg2,
    output logic              load_reg3,
    output logic              op,
    output logic [SEL_W-1:0]  mux_load_reg1,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              mul_start
);

    state_t            state;
    state_t            next_state;
    logic              mode_q;
    logic              start_accept;
    logic              cnt_clear;
    logic              cnt_inc;
    logic [ADDR_W-1:0] idx;
    logic              last;

    assign start_accept = (state == S_IDLE) && start && !abort;

    term_counter #(
        .N_TERMS (N_TERMS),
        .ADDR_W  (ADDR_W)
    ) u_term_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .load      (start_accept),
        .inc       (cnt_inc),
        .cfg_terms (cfg_terms),
        .idx       (idx),
        .last      (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Add/sub mode captured when a run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (start_accept) begin
            mode_q <= mode;
        end
    end

    // Next-state and Moore output decode; load_reg3 follows mul_done in WAIT.
    always_comb begin
        next_state    = state;
        busy          = 1'b0;
        done          = 1'b0;
        load_reg1     = 1'b0;
        load_reg2     = 1'b0;
        load_reg3     = 1'b0;
        op            = 1'b0;
        mux_load_reg1 = SEL_W'(SEL_ZERO);
        rom_addr      = '0;
        mul_start     = 1'b0;
        cnt_inc       = 1'b0;
        cnt_clear     = 1'b0;

        if (state != S_IDLE) begin
            busy = 1'b1;
            op   = mode_q;
        end

        case (state)
            S_IDLE: begin
                if (start_accept) begin
                    next_state = S_INIT;
                end
            end
            S_INIT: begin
                rom_addr      = '0;
                mux_load_reg1 = SEL_W'(SEL_ROM);
                load_reg1     = 1'b1;
                load_reg2     = 1'b1;
                next_state    = last ? S_DONE : S_MUL;
            end
            S_MUL: begin
                mul_start  = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                load_reg3 = mul_done;
                if (mul_done) begin
                    cnt_inc    = 1'b1;
                    next_state = S_ADD;
                end
            end
            S_ADD: begin
                rom_addr      = idx;
                mux_load_reg1 = SEL_W'(SEL_SUM);
                load_reg1     = 1'b1;
                next_state    = last ? S_DONE : S_MUL;
            end
            S_DONE: begin
                done       = 1'b1;
                cnt_clear  = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Abort overrides the transition only; this cycle's strobes stand.
        if (abort && (state != S_IDLE)) begin
            next_state = S_IDLE;
            cnt_clear  = 1'b1;
        end
    end

endmodule

// File: tb/tb_controle_horner.sv
// Self-checking bench for controle_horner: table-driven runs plus corner sequences.
module tb_controle_horner;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned SEL_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              mode;
    logic [ADDR_W-1:0] cfg_terms;
    logic              mul_done;
    logic              busy;
    logic              done;
    logic              load_reg1;
    logic              load_reg2;
    logic              load_reg3;
    logic              op;
    logic [SEL_W-1:0]  mux_load_reg1;
    logic [ADDR_W-1:0] rom_addr;
    logic              mul_start;

    int tests;
    int fails;

    controle_horner #(
        .N_TERMS (4),
        .ADDR_W  (ADDR_W),
        .SEL_W   (SEL_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .mode          (mode),
        .cfg_terms     (cfg_terms),
        .mul_done      (mul_done),
        .busy          (busy),
        .done          (done),
        .load_reg1     (load_reg1),
        .load_reg2     (load_reg2),
        .load_reg3     (load_reg3),
        .op            (op),
        .mux_load_reg1 (mux_load_reg1),
        .rom_addr      (rom_addr),
        .mul_start     (mul_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cfg;
        logic       mode;
        int         lat;       // multiplier latency L
        bit         spur;      // extra mul_done pulses in the ADD and following cycle
        int         start_at;  // cycle with a start pulse while busy (0 = none)
        int         abort_at;  // cycle with abort high (0 = none)
        int         exp_done;  // cycle of done pulse (0 = none)
        int         exp_busy;  // number of busy cycles
        int         exp_ms;    // mul_start pulses
        int         exp_l3;    // load_reg3 pulses
        int         exp_seq;   // rom_addr+1 nibbles of each load_reg1, in order
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One evaluation; cycle 0 is the edge sampling start, loop index = cycle number.
    task automatic run(input int id, input vec_t v);
        int  cnt = 0;
        int  spur_left = 0;
        int  done_cyc = 0;
        int  busy_cnt = 0;
        int  ms = 0;
        int  l3 = 0;
        int  seq = 0;
        int  op_err = 0;
        int  mux_err = 0;
        int  nloads = 0;
        int  exp_mux;
        bit  md_next = 1'b0;
        bit  init_ok = 1'b0;
        bit  ended = 1'b0;

        @(posedge clk);
        #1;
        cfg_terms = v.cfg;
        mode      = v.mode;
        start     = 1'b1;
        abort     = 1'b0;
        mul_done  = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            start    = (k == v.start_at);
            abort    = 1'b0;
            mul_done = md_next;
            @(negedge clk);
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            busy_cnt++;
            if (done) done_cyc = k;
            if (mul_start) begin
                ms++;
                cnt = v.lat;
            end
            if (load_reg3) l3++;
            if (op != v.mode) op_err++;
            if (load_reg1) begin
                seq     = seq * 16 + int'(rom_addr) + 1;
                exp_mux = (nloads == 0) ? 1 : 2;
                if (int'(mux_load_reg1) != exp_mux) mux_err++;
                nloads++;
            end else if (mux_load_reg1 != '0) begin
                mux_err++;
            end
            if (k == 1)
                init_ok = load_reg1 && load_reg2 && (mux_load_reg1 == 3'd1) && (rom_addr == '0);
            if (k == v.abort_at) abort = 1'b1;
            md_next = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    md_next   = 1'b1;
                    spur_left = v.spur ? 2 : 0;
                end
            end else if (spur_left > 0) begin
                spur_left--;
                md_next = 1'b1;
            end
        end
        start    = 1'b0;
        abort    = 1'b0;
        mul_done = 1'b0;

        check($sformatf("v%0d ended", id), int'(ended), 1);
        check($sformatf("v%0d done_cycle", id), done_cyc, v.exp_done);
        check($sformatf("v%0d busy_cycles", id), busy_cnt, v.exp_busy);
        check($sformatf("v%0d mul_starts", id), ms, v.exp_ms);
        check($sformatf("v%0d load_reg3s", id), l3, v.exp_l3);
        check($sformatf("v%0d addr_seq", id), seq, v.exp_seq);
        check($sformatf("v%0d op_errors", id), op_err, 0);
        check($sformatf("v%0d mux_errors", id), mux_err, 0);
        check($sformatf("v%0d init_decode", id), int'(init_ok), 1);
    endtask

    function automatic int all_outputs();
        return int'({busy, done, load_reg1, load_reg2, load_reg3, op,
                     mux_load_reg1, rom_addr, mul_start});
    endfunction

    initial begin
        tests     = 0;
        fails     = 0;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 1'b0;
        cfg_terms = '0;
        mul_done  = 1'b0;
        rst_n     = 1'b1;

        //          cfg    mode  L  spur st ab done busy ms l3 seq
        vecs[0] = '{4'd1,  1'b0, 1, 1'b0, 0, 0,  2,  2, 0, 0, 'h1};
        vecs[1] = '{4'd4,  1'b0, 1, 1'b0, 5, 0, 11, 11, 3, 3, 'h1234};
        vecs[2] = '{4'd3,  1'b1, 5, 1'b1, 0, 0, 16, 16, 2, 2, 'h123};
        vecs[3] = '{4'd0,  1'b1, 1, 1'b0, 0, 0,  2,  2, 0, 0, 'h1};
        vecs[4] = '{4'd15, 1'b0, 2, 1'b0, 0, 0, 14, 14, 3, 3, 'h1234};
        vecs[5] = '{4'd2,  1'b1, 3, 1'b1, 0, 0,  7,  7, 1, 1, 'h12};
        vecs[6] = '{4'd4,  1'b1, 3, 1'b0, 0, 9,  0,  9, 2, 1, 'h12};

        // Power-on reset: outputs must be zero asynchronously.
        #1 rst_n = 1'b0;
        #2 check("reset_outputs", all_outputs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during WAIT, then a full run.
        @(posedge clk); #1;
        cfg_terms = 4'd4; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrun_busy_before_reset", int'(busy), 1);
        check("midrun_op_before_reset", int'(op), 1);
        rst_n = 1'b0;
        #1 check("midrun_reset_outputs", all_outputs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(100, vecs[1]);

        // Start together with abort in IDLE is refused.
        @(posedge clk); #1;
        cfg_terms = 4'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", int'(busy), 0);
        check("start_abort_idle_outputs", all_outputs(), 0);

        for (int i = 0; i < 7; i++) begin
            run(i, vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
